// File: rtl/arm_pkg.sv
// Shared encodings for the multicycle Armv4-subset controller: states, datapath
// select codes, instruction field constants and the decode helpers.
package arm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTER,
        S_EXECUTEI,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALU_RESULT = 2'b00;
    localparam logic [1:0] RES_READ_DATA  = 2'b01;
    localparam logic [1:0] RES_ALU_OUT    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP     = 2'b00;
    localparam logic [1:0] IMM_MEM    = 2'b01;
    localparam logic [1:0] IMM_BRANCH = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Ungated control word; branch/writeback/memory_write still need cond_pass.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       writeback;
        logic       memory_write;
        logic       address_source;
        logic       instruction_write;
        logic [1:0] result_source;
        logic       ALU_source_a;
        logic [1:0] ALU_source_b;
        logic [1:0] ALU_control;
        logic [1:0] immediate_source;
    } ctrl_t;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

    function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
        logic [1:0] alu;
        case (cmd)
            CMD_SUB: alu = ALU_SUB;
            CMD_AND: alu = ALU_AND;
            CMD_ORR: alu = ALU_ORR;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [1:0] op, input logic [5:0] funct);
        state_t nxt;
        case (s)
            S_FETCH:    nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:     nxt = cmd_supported(funct[4:1]) ? (funct[5] ? S_EXECUTEI : S_EXECUTER) : S_FETCH;
                    OP_MEM:    nxt = S_MEMADR;
                    OP_BRANCH: nxt = S_BRANCH;
                    default:   nxt = S_FETCH;
                endcase
            end
            S_EXECUTER: nxt = S_ALUWB;
            S_EXECUTEI: nxt = S_ALUWB;
            S_MEMADR:   nxt = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = S_MEMWB;
            default:    nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] cmd);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_write          = 1'b1;
                c.instruction_write = 1'b1;
                c.ALU_source_a      = 1'b1;
                c.ALU_source_b      = SRCB_FOUR;
                c.result_source     = RES_ALU_OUT;
            end
            S_DECODE: begin
                c.ALU_source_a = 1'b1;
                c.ALU_source_b = SRCB_FOUR;
            end
            S_EXECUTER: begin
                c.ALU_source_b = SRCB_REG;
                c.ALU_control  = cmd_to_alu(cmd);
            end
            S_EXECUTEI: begin
                c.ALU_source_b     = SRCB_IMM;
                c.immediate_source = IMM_DP;
                c.ALU_control      = cmd_to_alu(cmd);
            end
            S_MEMADR: begin
                c.ALU_source_b     = SRCB_IMM;
                c.immediate_source = IMM_MEM;
            end
            S_MEMREAD:  c.address_source = 1'b1;
            S_MEMWB: begin
                c.result_source = RES_READ_DATA;
                c.writeback     = 1'b1;
            end
            S_MEMWRITE: begin
                c.address_source = 1'b1;
                c.memory_write   = 1'b1;
            end
            S_ALUWB: begin
                c.result_source = RES_ALU_RESULT;
                c.writeback     = 1'b1;
            end
            S_BRANCH: begin
                c.immediate_source = IMM_BRANCH;
                c.ALU_source_b     = SRCB_IMM;
                c.result_source    = RES_ALU_OUT;
                c.branch           = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction register fields and ALU flags in,
// mux selects and write enables out.
interface multicycle_controller_if;
    logic [31:12] instruction;
    logic [3:0]   ALU_flags;
    logic         pc_write;
    logic         address_source;
    logic         instruction_write;
    logic         memory_write;
    logic         register_write;
    logic [1:0]   result_source;
    logic         ALU_source_a;
    logic [1:0]   ALU_source_b;
    logic [1:0]   ALU_control;
    logic [1:0]   immediate_source;
    logic [1:0]   register_source;

    modport master (
        input  instruction, ALU_flags,
        output pc_write, address_source, instruction_write, memory_write, register_write,
               result_source, ALU_source_a, ALU_source_b, ALU_control, immediate_source,
               register_source
    );

    modport slave (
        output instruction, ALU_flags,
        input  pc_write, address_source, instruction_write, memory_write, register_write,
               result_source, ALU_source_a, ALU_source_b, ALU_control, immediate_source,
               register_source
    );
endinterface

// File: rtl/condition_check.sv
// NZCV flags register and condition-field evaluation. cond_pass uses the stored
// flags only, so a flag-setting instruction is judged on the pre-update value.
module condition_check
    import arm_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] cmd,
    input  logic       s_bit,
    input  logic       execute,
    input  logic [3:0] ALU_flags,
    output logic       cond_pass
);
    logic [3:0] flags;

    assign cond_pass = cond_holds(cond, flags);

    // Logical ops leave C and V untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (execute && s_bit && cond_pass) begin
            flags[3:2] <= ALU_flags[3:2];
            if (cmd == CMD_ADD || cmd == CMD_SUB) begin
                flags[1:0] <= ALU_flags[1:0];
            end
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencing controller: state register, next-state logic and
// registered control decode, with write enables gated by cond_pass.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4
// DECODE     | read register file, ALU computes PC+8
// EXECUTER   | data processing, register operand
// EXECUTEI   | data processing, immediate operand
// MEMADR     | base + 12-bit offset
// MEMREAD    | read data memory at computed address
// MEMWB      | write loaded data to Rd
// MEMWRITE   | store Rd at computed address
// ALUWB      | write ALU result to Rd
// BRANCH     | PC <= PC+8 + offset
module multicycle_controller (
    input logic                    clock,
    input logic                    reset,
    multicycle_controller_if.master bus
);
    import arm_pkg::*;

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       execute;
    logic       cond_pass;
    logic       rd_is_pc;
    logic       unused_rn;

    assign cond      = bus.instruction[31:28];
    assign op        = bus.instruction[27:26];
    assign funct     = bus.instruction[25:20];
    assign cmd       = funct[4:1];
    assign rd        = bus.instruction[15:12];
    assign unused_rn = ^bus.instruction[19:16];

    assign state_nxt = next_state(state, op, funct);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            ctrl  <= decode_ctrl(S_FETCH, CMD_ADD);
        end else begin
            state <= state_nxt;
            ctrl  <= decode_ctrl(state_nxt, cmd);
        end
    end

    assign execute = (state == S_EXECUTER) || (state == S_EXECUTEI);

    condition_check u_condition_check (
        .clock     (clock),
        .reset     (reset),
        .cond      (cond),
        .cmd       (cmd),
        .s_bit     (funct[0]),
        .execute   (execute),
        .ALU_flags (bus.ALU_flags),
        .cond_pass (cond_pass)
    );

    // A writeback to R15 becomes a PC load instead of a register-file write.
    assign rd_is_pc = (rd == 4'hF);

    assign bus.pc_write          = reset & (ctrl.pc_write |
                                            (cond_pass & (ctrl.branch | (ctrl.writeback & rd_is_pc))));
    assign bus.register_write    = reset & cond_pass & ctrl.writeback & ~rd_is_pc;
    assign bus.memory_write      = reset & cond_pass & ctrl.memory_write;
    assign bus.instruction_write = reset & ctrl.instruction_write;

    assign bus.address_source   = ctrl.address_source;
    assign bus.result_source    = ctrl.result_source;
    assign bus.ALU_source_a     = ctrl.ALU_source_a;
    assign bus.ALU_source_b     = ctrl.ALU_source_b;
    assign bus.ALU_control      = ctrl.ALU_control;
    assign bus.immediate_source = ctrl.immediate_source;

    // The instruction register is still loading during FETCH.
    assign bus.register_source = (state == S_FETCH) ? 2'b00 : {op == OP_MEM, op == OP_BRANCH};
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model predicts
// the per-cycle control word, a negedge process compares it against the DUT.
module tb_multicycle_controller;
    logic clock = 1'b0;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  mflags = 4'b0000;
    logic [15:0] exp_q[$];
    string       name_q[$];
    logic [15:0] cmp_e;
    string       cmp_nm;
    logic [15:0] outs;

    assign outs = {bus.pc_write, bus.address_source, bus.instruction_write, bus.memory_write,
                   bus.register_write, bus.result_source, bus.ALU_source_a, bus.ALU_source_b,
                   bus.ALU_control, bus.immediate_source, bus.register_source};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rec(input logic pcw, input logic adr, input logic irw,
                                        input logic memw, input logic regw, input logic [1:0] res,
                                        input logic srca, input logic [1:0] srcb, input logic [1:0] alu,
                                        input logic [1:0] imm, input logic [1:0] rs);
        return {pcw, adr, irw, memw, regw, res, srca, srcb, alu, imm, rs};
    endfunction

    // Armv4 conditions: even codes test a base predicate, odd codes its inverse.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? ~base : base;
    endfunction

    task automatic push(input string nm, input logic [15:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic model_push(input string tag, input logic [31:12] ins, input logic [3:0] exf,
                              output int n);
        logic [3:0] cond, cmd, rd;
        logic [1:0] op, alu, rs;
        logic [5:0] funct;
        logic       cp, dp_ok, to_pc;
        int         n0;
        n0    = exp_q.size();
        cond  = ins[31:28];
        op    = ins[27:26];
        funct = ins[25:20];
        cmd   = funct[4:1];
        rd    = ins[15:12];
        to_pc = (rd == 4'hF);
        rs    = {op == 2'b01, op == 2'b10};
        dp_ok = 1'b1;
        alu   = 2'b00;
        case (cmd)
            4'b0100: alu = 2'b00;
            4'b0010: alu = 2'b01;
            4'b0000: alu = 2'b10;
            4'b1100: alu = 2'b11;
            default: dp_ok = 1'b0;
        endcase
        push({tag, " fetch"},  rec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00));
        push({tag, " decode"}, rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, rs));
        if (op == 2'b00 && dp_ok) begin
            cp = cond_ok(cond, mflags);
            push({tag, " execute"}, rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                        funct[5] ? 2'b01 : 2'b00, alu, 2'b00, rs));
            if (funct[0] && cp) begin
                mflags[3:2] = exf[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010) mflags[1:0] = exf[1:0];
            end
            cp = cond_ok(cond, mflags);
            push({tag, " aluwb"}, rec(cp & to_pc, 1'b0, 1'b0, 1'b0, cp & ~to_pc, 2'b00, 1'b0,
                                      2'b00, 2'b00, 2'b00, rs));
        end else if (op == 2'b01) begin
            cp = cond_ok(cond, mflags);
            push({tag, " memadr"}, rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, rs));
            if (funct[0]) begin
                push({tag, " memread"}, rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, rs));
                push({tag, " memwb"},   rec(cp & to_pc, 1'b0, 1'b0, 1'b0, cp & ~to_pc, 2'b01, 1'b0,
                                            2'b00, 2'b00, 2'b00, rs));
            end else begin
                push({tag, " memwrite"}, rec(1'b0, 1'b1, 1'b0, cp, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, rs));
            end
        end else if (op == 2'b10) begin
            cp = cond_ok(cond, mflags);
            push({tag, " branch"}, rec(cp, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10, rs));
        end
        n = exp_q.size() - n0;
    endtask

    // Starts in FETCH just after a rising edge; instruction is junk during FETCH.
    task automatic run(input string tag, input logic [31:12] ins, input logic [3:0] exf);
        int n;
        model_push(tag, ins, exf, n);
        for (int k = 0; k < n; k++) begin
            bus.instruction = (k == 0) ? 20'($urandom) : ins;
            bus.ALU_flags   = (k == 2) ? exf : ~exf;
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cmp_e  = exp_q.pop_front();
            cmp_nm = name_q.pop_front();
            chk(cmp_nm, outs, cmp_e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    localparam logic [31:12] LDR_EQ  = {4'b0000, 2'b01, 6'b011001, 4'b0010, 4'b0100};
    localparam logic [31:12] LDR_AL  = {4'b1110, 2'b01, 6'b011001, 4'b0010, 4'b0110};
    localparam logic [31:12] ADDS_AL = {4'b1110, 2'b00, 6'b001001, 4'b0010, 4'b0001};
    localparam logic [31:12] STR_AL  = {4'b1110, 2'b01, 6'b011000, 4'b0010, 4'b0101};
    localparam logic [31:12] SUBS_AL = {4'b1110, 2'b00, 6'b000101, 4'b0011, 4'b0111};
    localparam logic [31:12] ORRS_AL = {4'b1110, 2'b00, 6'b011001, 4'b0011, 4'b1000};
    localparam logic [31:12] B_LT    = {4'b1011, 2'b10, 6'b100000, 4'b0000, 4'b0000};
    localparam logic [31:12] ADDI_PC = {4'b1110, 2'b00, 6'b101000, 4'b0001, 4'b1111};
    localparam logic [31:12] ADDS_NV = {4'b1111, 2'b00, 6'b001001, 4'b0010, 4'b0001};
    localparam logic [31:12] EOR_AL  = {4'b1110, 2'b00, 6'b000010, 4'b0010, 4'b0001};
    localparam logic [31:12] OP11_AL = {4'b1110, 2'b11, 6'b000000, 4'b0000, 4'b0000};

    initial begin
        reset           = 1'b0;
        bus.instruction = '0;
        bus.ALU_flags   = 4'b1111;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst pc_write", 16'(bus.pc_write), 16'd0);
        chk("rst instruction_write", 16'(bus.instruction_write), 16'd0);
        chk("rst outputs", outs, 16'h0580);
        chk("rst flags", 16'(dut.u_condition_check.flags), 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("release fetch outputs", outs, 16'hA580);

        run("ldr_eq_z0", LDR_EQ, 4'b0000);
        run("adds", ADDS_AL, 4'b0110);
        chk("adds flags", 16'(dut.u_condition_check.flags), 16'h0006);
        chk("model adds flags", 16'(mflags), 16'h0006);
        run("ldr_eq_z1", LDR_EQ, 4'b0000);
        run("str", STR_AL, 4'b0000);
        run("subs", SUBS_AL, 4'b1010);
        chk("subs flags", 16'(dut.u_condition_check.flags), 16'h000A);
        run("b_lt_taken", B_LT, 4'b0000);
        run("orrs", ORRS_AL, 4'b0001);
        chk("orrs flags keep cv", 16'(dut.u_condition_check.flags), 16'h0002);
        chk("model orrs flags", 16'(mflags), 16'h0002);
        run("b_lt_not_taken", B_LT, 4'b0000);
        run("addi_pc", ADDI_PC, 4'b0000);
        run("adds_nv", ADDS_NV, 4'b1111);
        chk("nv flags held", 16'(dut.u_condition_check.flags), 16'h0002);
        run("eor_noop", EOR_AL, 4'b0000);
        run("op11_noop", OP11_AL, 4'b0000);

        // Abort an LDR in MEMREAD with reset.
        bus.instruction = 20'($urandom);
        @(posedge clock);
        #1;
        bus.instruction = LDR_AL;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("memread address_source", 16'(bus.address_source), 16'd1);
        reset = 1'b0;
        #1;
        chk("abort enables", 16'({bus.pc_write, bus.instruction_write, bus.memory_write, bus.register_write}), 16'd0);
        chk("abort outputs", outs, 16'h0580);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("abort held outputs", outs, 16'h0580);
        chk("abort flags", 16'(dut.u_condition_check.flags), 16'd0);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        mflags = 4'b0000;
        #1;
        chk("restart fetch outputs", outs, 16'hA580);
        run("ldr_eq_after_reset", LDR_EQ, 4'b0000);
        run("adds_after_reset", ADDS_AL, 4'b0100);
        run("ldr_eq_after_adds", LDR_EQ, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
